mux_nx1_reg: RTL
================

MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel in bits (1..64).
REQ-002 SHALL have parameter N, default 4, number of input channels (2..16); SW = $clog2(N).
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port A  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port A_VALID  input  N  per-channel valid.
REQ-007 SHALL have port A_READY  output  N  per-channel ready; a beat transfers on channel i when A_VALID[i] and A_READY[i] are both 1 at a rising edge.
REQ-008 SHALL have port SEL  input  SW  channel select, used in fixed mode.
REQ-009 SHALL have port Y  output  WIDTH  registered output data.
REQ-010 SHALL have port Y_VALID  output  1  Y holds a beat.
REQ-011 SHALL have port Y_READY  input  1  downstream accepts Y when Y_VALID and Y_READY are both 1.
REQ-012 SHALL have port GRANT  output  SW  index of the channel whose beat is currently in Y.

Function
REQ-013 Output stage SHALL be a single register; it loads when empty (Y_VALID=0) or being drained (Y_VALID=1 and Y_READY=1) in the same cycle.
REQ-014 At most one bit of A_READY SHALL be 1 in any cycle, namely the selected channel, and only while the output stage can load.
REQ-015 A_READY SHALL be combinational from Y_VALID, Y_READY, SEL/pointer and A_VALID; Y, Y_VALID and GRANT SHALL be registered only.
REQ-016 Latency SHALL be 1 cycle: a beat accepted at edge k appears on Y with Y_VALID=1 after edge k.
REQ-017 Simultaneous drain and load SHALL sustain one beat per cycle with no bubble.
REQ-018 Drain with no load (selected channel not valid) SHALL clear Y_VALID; Y and GRANT SHALL hold their last values.
REQ-019 While Y_VALID=1 and Y_READY=0, Y, Y_VALID and GRANT SHALL hold and all A_READY SHALL be 0.
REQ-020 Fixed mode: selected channel = SEL; if SEL >= N (N not a power of two), no channel SHALL be selected and all A_READY SHALL be 0.
REQ-021 SEL changes SHALL take effect in the same cycle for A_READY; a beat already in Y is unaffected.
REQ-022 Y SHALL equal the transferred channel's data bit-exactly; no truncation or extension.

Reset
REQ-023 On RST_N=0, immediately and independent of CLK: Y=0, Y_VALID=0, GRANT=0, round-robin pointer=N-1, A_READY=0.
REQ-024 Reset mid-transfer SHALL discard the beat held in Y; no partial state SHALL survive.
REQ-025 After RST_N deasserts, the first load SHALL occur no earlier than the first rising edge with RST_N=1.

Configuration
REQ-026 Macro MUX_NX1_RR_EN, when defined, SHALL compile in round-robin mode: SEL is ignored and the selected channel is the first channel with A_VALID=1 searching cyclically from pointer+1; the pointer updates to the granted index on each transfer and is unchanged otherwise.
REQ-027 With MUX_NX1_RR_EN defined and no channel valid, no channel SHALL be selected; pointer wrap from N-1 SHALL go to 0.
REQ-028 Without MUX_NX1_RR_EN, only fixed mode (REQ-020) SHALL exist and no pointer register SHALL be synthesised.

Verification (WIDTH=8, N=4)
REQ-029 Fixed, A ch0=8'h55 valid, ch1=8'hAA valid, SEL=0, Y_READY=1 -> next cycle Y=8'h55, GRANT=0, A_READY=4'b0001; set SEL=1 -> next cycle Y=8'hAA, GRANT=1.
REQ-030 Fixed, Y_READY=0 for 3 cycles with ch2 valid, SEL=2 -> Y holds first beat, A_READY=0 for all 3 cycles; Y_READY=1 -> next beat loads with no bubble.
REQ-031 RR, all four valid continuously, Y_READY=1 -> GRANT sequence 0,1,2,3,0,1 after reset.
REQ-032 RR, only ch1 and ch3 valid -> GRANT alternates 1,3,1,3; pointer wraps 3->1 via 0 and 2 skipped.
REQ-033 RST_N pulsed low mid-stream while Y_VALID=1 -> Y=0, Y_VALID=0, A_READY=0 immediately, no clock edge required; first post-reset grant (RR) is channel 0.
REQ-034 Drain with selected channel idle -> Y_VALID falls to 0 next cycle, Y retains last value.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// N:1 valid/ready mux into a single output register; 1-cycle latency, A_READY only toward the selected channel while Y is empty or draining.
// Fixed SEL selection by default; define MUX_NX1_RR_EN for round-robin arbitration (SEL ignored).
module mux_nx1_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N*WIDTH-1:0] A,
  input  logic [N-1:0]       A_VALID,
  output logic [N-1:0]       A_READY,
  input  logic [SW-1:0]      SEL,
  output logic [WIDTH-1:0]   Y,
  output logic               Y_VALID,
  input  logic               Y_READY,
  output logic [SW-1:0]      GRANT
);

  logic [WIDTH-1:0] r_y;
  logic             r_y_vld;
  logic [SW-1:0]    r_grant;

  logic             w_can_load;
  logic             w_sel_ok;
  logic [SW-1:0]    w_sel;
  logic             w_in_vld;
  logic [WIDTH-1:0] w_in_dat;
  logic             w_load;

`ifdef MUX_NX1_RR_EN
  logic [SW-1:0] r_ptr;
  logic          w_hi_ok;
  logic [SW-1:0] w_hi_idx;
  logic          w_lo_ok;
  logic [SW-1:0] w_lo_idx;
  logic          w_unused_sel;

  assign w_unused_sel = ^SEL;

  // Cyclic search from r_ptr+1: lowest valid index above the pointer wins,
  // otherwise wrap to the lowest valid index at or below it.
  always_comb begin
    w_hi_ok  = 1'b0;
    w_hi_idx = '0;
    w_lo_ok  = 1'b0;
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (A_VALID[i]) begin
        if (i > int'(r_ptr)) begin
          w_hi_ok  = 1'b1;
          w_hi_idx = SW'(i);
        end else begin
          w_lo_ok  = 1'b1;
          w_lo_idx = SW'(i);
        end
      end
    end
    w_sel_ok = w_hi_ok | w_lo_ok;
    w_sel    = w_hi_ok ? w_hi_idx : w_lo_idx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr <= SW'(N - 1);
    end else if (w_load) begin
      r_ptr <= w_sel;
    end
  end
`else
  always_comb begin
    w_sel    = SEL;
    w_sel_ok = (int'(SEL) < N);
  end
`endif

  always_comb begin
    w_in_dat = '0;
    w_in_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_sel_ok && (SW'(i) == w_sel)) begin
        w_in_dat = A[i*WIDTH +: WIDTH];
        w_in_vld = A_VALID[i];
      end
    end
  end

  // Reset gates ready so nothing is offered while RST_N is low.
  assign w_can_load = RST_N && (!r_y_vld || Y_READY);
  assign w_load     = w_can_load && w_sel_ok && w_in_vld;

  always_comb begin
    A_READY = '0;
    for (int i = 0; i < N; i++) begin
      A_READY[i] = w_can_load && w_sel_ok && (SW'(i) == w_sel);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_y     <= '0;
      r_y_vld <= 1'b0;
      r_grant <= '0;
    end else if (w_load) begin
      r_y     <= w_in_dat;
      r_y_vld <= 1'b1;
      r_grant <= w_sel;
    end else if (w_can_load) begin
      r_y_vld <= 1'b0;
    end
  end

  assign Y       = r_y;
  assign Y_VALID = r_y_vld;
  assign GRANT   = r_grant;

endmodule
